dmem_responder: RTL and testbench

Data-memory responder for the multi-cycle IF/EX/MEM core. It accepts one load/store per MEM stage from the EX→MEM latch and runs a request/acknowledge handshake with a variable-latency data memory. It holds the stage controller in MEM through `mem_force` until the access completes, then presents registered load data for the register-file write. It is the memory-side counterpart of the stage sequencer's `mem_inst`/`mem_force` interface.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_responder_if.sv | 42 ++++
 rtl/dmem_responder.sv | 120 ++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default bus widths and the timeout-counter width.
package dmem_responder_pkg;

  localparam int unsigned AW_DEF      = 16;
  localparam int unsigned DW_DEF      = 16;

  // TIMEOUT ranges over 0..255, so an 8-bit counter always reaches TIMEOUT-1.
  localparam int unsigned TIMEOUT_MAX = 255;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : dmem_responder_pkg

// File: rtl/dmem_responder_if.sv
// Request/acknowledge bus between the responder and the variable-latency
// data memory.
//   mem_req   : request, high for the whole outstanding access
//   mem_we    : write enable, valid with mem_req
//   mem_addr  : address, valid with mem_req
//   mem_wdata : write data, valid with mem_req
//   mem_ack   : completion from memory
//   mem_rdata : read data, valid with mem_ack on a load
// master = responder side, slave = memory side.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface : dmem_responder_if

// File: rtl/dmem_responder.sv
// Data-memory responder for the multi-cycle IF/EX/MEM core. Launches one
// load/store per MEM stage, holds the stage controller with mem_force while
// the memory access is outstanding, and returns registered load data.
//   clk, resetn           : clock, asynchronous active-low reset
//   start, is_store       : access launch and direction, sampled in IDLE
//   addr, wdata           : access address and store data, sampled with start
//   mem_force             : stall to the stage controller (state == BUSY)
//   load_data             : registered load result
//   bus_err               : sticky timeout flag, cleared only by reset
//   mem                   : memory request/acknowledge bus (master side)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              is_store,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic              mem_force,
  output logic [DW-1:0]     load_data,
  output logic              bus_err,
  dmem_responder_if.master  mem
);

  // Timeout on the cycle the counter holds TIMEOUT-1, so BUSY lasts exactly
  // TIMEOUT cycles; TIMEOUT == 0 disables the check entirely.
  localparam logic             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e           state_q,     state_d;
  logic             we_q,        we_d;
  logic [AW-1:0]    addr_q,      addr_d;
  logic [DW-1:0]    wdata_q,     wdata_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [DW-1:0]    load_data_q, load_data_d;
  logic             bus_err_q,   bus_err_d;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          we_d    = is_store;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // Ack takes priority over a coincident timeout.
        if (mem.mem_ack) begin
          if (!we_q) begin
            load_data_d = mem.mem_rdata;
          end
          state_d = ST_DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          bus_err_d   = 1'b1;
          load_data_d = '0;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Bus and stall outputs are decoded from registers only; no path from mem_ack.
  assign mem_force     = (state_q == ST_BUSY);
  assign mem.mem_req   = (state_q == ST_BUSY);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign load_data     = load_data_q;
  assign bus_err       = bus_err_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed accesses with a scoreboard queue of
// expected completions consumed by an independent bus/completion monitor.
module tb_dmem_responder;

  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 16;
  localparam int unsigned TIMEOUT = 15;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ld;
    logic          err;
    int            busy;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          is_store;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          mem_force;
  logic [DW-1:0] load_data;
  logic          bus_err;

  dmem_responder_if #(.AW(AW), .DW(DW)) mem_if ();

  dmem_responder #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .is_store  (is_store),
    .addr      (addr),
    .wdata     (wdata),
    .mem_force (mem_force),
    .load_data (load_data),
    .bus_err   (bus_err),
    .mem       (mem_if)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: checks every request cycle against the head expectation and
  // scores each completion (falling edge of mem_force) against it.
  int   busy_cnt   = 0;
  logic prev_force = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      busy_cnt   = 0;
      prev_force = 1'b0;
    end else begin
      if (mem_if.mem_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 64'(mem_if.mem_addr), 64'hFFFF_FFFF);
        end else begin
          chk("req_addr", 64'(mem_if.mem_addr), 64'(exp_q[0].addr));
          chk("req_we",   64'(mem_if.mem_we),   64'(exp_q[0].we));
          if (exp_q[0].we) chk("req_wdata", 64'(mem_if.mem_wdata), 64'(exp_q[0].wdata));
        end
        busy_cnt++;
      end
      if (prev_force && !mem_force) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(load_data), 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("busy_cycles", 64'(busy_cnt),  64'(e.busy));
          chk("load_data",   64'(load_data), 64'(e.ld));
          chk("bus_err",     64'(bus_err),   64'(e.err));
        end
        busy_cnt = 0;
      end
      prev_force = mem_force;
    end
  end

  // One access: waits < 0 means the memory never acks.
  task automatic run_access(input logic st, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            input int waits, input logic [DW-1:0] rd,
                            input logic [DW-1:0] exp_ld, input logic exp_err, input int exp_busy);
    exp_t e;
    e.addr = a; e.we = st; e.wdata = wd; e.ld = exp_ld; e.err = exp_err; e.busy = exp_busy;
    @(negedge clk);
    start = 1'b1; is_store = st; addr = a; wdata = wd;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; is_store = 1'b0; addr = '0; wdata = '0;
    if (waits >= 0) begin
      repeat (waits) @(negedge clk);
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = rd;
      @(negedge clk);
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    end else begin
      repeat (TIMEOUT) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    resetn = 1'b0; start = 1'b0; is_store = 1'b0; addr = '0; wdata = '0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    #12;
    chk("reset_outputs",
        64'({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_force, load_data, bus_err}),
        64'(0));
    @(posedge clk); #2 resetn = 1'b1;

    // Load, ack in first BUSY cycle.
    run_access(1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 1'b0, 1);
    // Store, ack after 3 wait cycles; load_data keeps BEEF.
    run_access(1'b1, 16'h1234, 16'hA5A5, 3, 16'h9999, 16'hBEEF, 1'b0, 4);
    // Ack in the 15th BUSY cycle (the timeout cycle): ack wins.
    run_access(1'b0, 16'h0300, 16'h0000, 14, 16'hCAFE, 16'hCAFE, 1'b0, 15);
    // No ack: timeout after exactly 15 BUSY cycles.
    run_access(1'b0, 16'h0100, 16'h0000, -1, 16'h0000, 16'h0000, 1'b1, 15);
    // bus_err stays set through a successful access.
    run_access(1'b0, 16'h0200, 16'h0000, 1, 16'h1357, 16'h1357, 1'b1, 2);

    // start pulsed during BUSY with a different address is ignored.
    e.addr = 16'h0400; e.we = 1'b0; e.wdata = '0; e.ld = 16'h1111; e.err = 1'b1; e.busy = 4;
    @(negedge clk);
    start = 1'b1; addr = 16'h0400; exp_q.push_back(e);
    @(negedge clk); start = 1'b0; addr = '0;
    @(negedge clk); start = 1'b1; addr = 16'h0800; is_store = 1'b1;
    @(negedge clk); start = 1'b0; addr = '0; is_store = 1'b0;
    @(negedge clk); mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'h1111;
    @(negedge clk); mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    @(negedge clk);
    chk("after_busy_start_idle", 64'({mem_force, mem_if.mem_req}), 64'(0));

    // Reset in the 2nd BUSY cycle clears everything immediately.
    e.addr = 16'h0500; e.we = 1'b0; e.wdata = '0; e.ld = '0; e.err = 1'b0; e.busy = 0;
    @(negedge clk);
    start = 1'b1; addr = 16'h0500; exp_q.push_back(e);
    @(negedge clk); start = 1'b0; addr = '0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midaccess_reset_outputs",
        64'({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_force, load_data, bus_err}),
        64'(0));
    @(negedge clk);
    @(posedge clk); #2 resetn = 1'b1;

    // Late ack in IDLE after reset is ignored.
    @(negedge clk); mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hFFFF;
    @(negedge clk); mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    chk("late_ack_idle", 64'({mem_force, mem_if.mem_req, load_data, bus_err}), 64'(0));

    // Normal access after reset release.
    run_access(1'b0, 16'h0600, 16'h0000, 0, 16'h2468, 16'h2468, 1'b0, 1);

    // Stray ack in IDLE leaves the result untouched.
    @(negedge clk); mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 16'hFFFF;
    @(negedge clk); mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
    @(negedge clk);
    chk("stray_ack_load_data", 64'(load_data), 64'h2468);
    chk("stray_ack_idle", 64'({mem_force, mem_if.mem_req}), 64'(0));

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_responder
